// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single registered memory port.
// Optional macro MEMARB_FAIR_EN: fetch gets the next grant after a data op that finished while fetch waited.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_type,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY,
        DONE
    } state_t;

    localparam logic [15:0] LP_LAST    = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LP_IF_TYPE = 3'b000;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_prio;
    logic        r_gnt_dm;
    logic        r_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_mem_type;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        w_gnt_dm;
    logic        w_gnt_if;
    logic        w_ack;
    logic        w_tmo;
    logic        w_prio_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_dm    = 1'b0;
        w_gnt_if    = 1'b0;
        w_ack       = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (dm_req && !(r_prio && if_req)) begin
                    w_gnt_dm    = 1'b1;
                    w_state_nxt = DM_BUSY;
                end else if (if_req) begin
                    w_gnt_if    = 1'b1;
                    w_state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                // An ack in the final allowed cycle still counts as success
                w_ack = mem_ack && r_mem_req;
                w_tmo = !w_ack && (r_cnt == LP_LAST);
                if (w_ack || w_tmo) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef MEMARB_FAIR_EN
    assign w_prio_set = (r_state == DM_BUSY) && (w_ack || w_tmo) && if_req;
`else
    assign w_prio_set = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_prio      <= 1'b0;
            r_gnt_dm    <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_type  <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            if (w_gnt_dm) begin
                r_mem_req   <= 1'b1;
                r_gnt_dm    <= 1'b1;
                r_cnt       <= '0;
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_we ? dm_wdata : 32'h0;
                r_mem_type  <= dm_type;
            end else if (w_gnt_if) begin
                r_mem_req   <= 1'b1;
                r_gnt_dm    <= 1'b0;
                r_cnt       <= '0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= 32'h0;
                r_mem_type  <= LP_IF_TYPE;
            end
            if (w_ack || w_tmo) begin
                r_mem_req <= 1'b0;
                if (r_gnt_dm) begin
                    r_dm_rdata <= w_ack ? mem_rdata : 32'h0;
                end else begin
                    r_if_rdata <= w_ack ? mem_rdata : 32'h0;
                end
            end else if (r_state == IF_BUSY || r_state == DM_BUSY) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
            if (w_gnt_if) begin
                r_prio <= 1'b0;
            end else if (w_prio_set) begin
                r_prio <= 1'b1;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_type  = r_mem_type;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ready  = (r_state == DONE) && !r_gnt_dm;
    assign dm_ready  = (r_state == DONE) && r_gnt_dm;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed table, corner sequences, random vs model.
module tb_mem_port_arbiter;

    localparam int TO = 4;
`ifdef MEMARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_type;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_type(dm_type),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_type(mem_type),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    // Transaction-level reference: one outstanding job, its age, and a finish flag
    bit          m_inflight, m_fin, m_dm, m_err, m_prio;
    int          m_age;
    logic        m_we;
    logic [31:0] m_addr, m_wd, m_if_rd, m_dm_rd;
    logic [2:0]  m_type;

    task automatic model_step();
        bit done;
        if (reset) begin
            m_inflight = 0; m_fin = 0; m_dm = 0; m_err = 0; m_prio = 0;
            m_age = 0; m_we = 0; m_addr = 0; m_wd = 0; m_type = 0;
            m_if_rd = 0; m_dm_rd = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_inflight) begin
            m_age++;
            done = 1;
            if (mem_ack) begin
                if (m_dm) m_dm_rd = mem_rdata; else m_if_rd = mem_rdata;
            end else if (m_age >= TO) begin
                m_err = 1;
                if (m_dm) m_dm_rd = 0; else m_if_rd = 0;
            end else begin
                done = 0;
            end
            if (done) begin
                m_inflight = 0;
                m_fin = 1;
                if (FAIR && m_dm && if_req) m_prio = 1;
            end
        end else if (dm_req && !(m_prio && if_req)) begin
            m_inflight = 1; m_dm = 1; m_age = 0;
            m_we = dm_we; m_addr = dm_addr; m_type = dm_type;
            m_wd = dm_we ? dm_wdata : 32'h0;
        end else if (if_req) begin
            m_inflight = 1; m_dm = 0; m_age = 0; m_prio = 0;
            m_we = 0; m_addr = if_addr; m_wd = 0; m_type = 0;
        end
    endtask

    function automatic logic [136:0] dut_vec();
        return {mem_req, mem_we, mem_addr, mem_wdata, mem_type, if_ready,
                if_rdata, dm_ready, dm_rdata, busy, err};
    endfunction

    function automatic logic [136:0] model_vec();
        return {m_inflight, m_we, m_addr, m_wd, m_type, m_fin && !m_dm,
                m_if_rd, m_fin && m_dm, m_dm_rd, m_inflight || m_fin, m_err};
    endfunction

    task automatic chk(input string name, input logic [136:0] act,
                       input logic [136:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic idle_in();
        reset = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; dm_type = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    typedef struct {
        logic rst, ifq; logic [31:0] ifa;
        logic dmq, dmwe; logic [31:0] dma, dmwd; logic [2:0] dmt;
        logic ack; logic [31:0] mrd;
        logic e_req, e_we; logic [31:0] e_addr, e_wd;
        logic e_ifr, e_dmr; logic [31:0] e_ifrd, e_dmrd;
        logic e_busy, e_err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cnt;
        int got;
        bit saw;
        bit seq[$];
        idle_in();
        reset = 1;

        tbl[0]  = '{1,0,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0, 0,0};
        tbl[1]  = '{0,1,32'h100, 0,0,0,0,0, 0,0,
                    1,0,32'h100,0, 0,0,0,0, 1,0};
        tbl[2]  = '{0,1,32'h100, 0,0,0,0,0, 0,0,
                    1,0,32'h100,0, 0,0,0,0, 1,0};
        tbl[3]  = tbl[2];
        tbl[4]  = '{0,1,32'h100, 0,0,0,0,0, 1,32'h00500093,
                    0,0,32'h100,0, 1,0,32'h00500093,0, 1,0};
        tbl[5]  = '{0,0,0, 0,0,0,0,0, 0,0,
                    0,0,32'h100,0, 0,0,32'h00500093,0, 0,0};
        tbl[6]  = '{0,1,32'h300, 1,1,32'h200,32'hDEADBEEF,3'd2, 0,0,
                    1,1,32'h200,32'hDEADBEEF, 0,0,32'h00500093,0, 1,0};
        tbl[7]  = '{0,1,32'h300, 1,1,32'h200,32'hDEADBEEF,3'd2, 1,32'h12345678,
                    0,1,32'h200,32'hDEADBEEF, 0,1,32'h00500093,32'h12345678, 1,0};
        tbl[8]  = '{0,1,32'h300, 0,0,0,0,0, 1,0,
                    0,1,32'h200,32'hDEADBEEF, 0,0,32'h00500093,32'h12345678, 0,0};
        tbl[9]  = '{0,1,32'h300, 0,0,0,0,0, 0,0,
                    1,0,32'h300,0, 0,0,32'h00500093,32'h12345678, 1,0};
        tbl[10] = '{0,1,32'h300, 0,0,0,0,0, 1,32'hCAFEF00D,
                    0,0,32'h300,0, 1,0,32'hCAFEF00D,32'h12345678, 1,0};
        tbl[11] = '{0,0,0, 0,0,0,0,0, 0,0,
                    0,0,32'h300,0, 0,0,32'hCAFEF00D,32'h12345678, 0,0};

        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; if_req = tbl[i].ifq; if_addr = tbl[i].ifa;
            dm_req = tbl[i].dmq; dm_we = tbl[i].dmwe; dm_addr = tbl[i].dma;
            dm_wdata = tbl[i].dmwd; dm_type = tbl[i].dmt;
            mem_ack = tbl[i].ack; mem_rdata = tbl[i].mrd;
            tick();
            chk($sformatf("table%0d", i),
                137'({mem_req, mem_we, mem_addr, mem_wdata, if_ready,
                      if_rdata, dm_ready, dm_rdata, busy, err}),
                137'({tbl[i].e_req, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wd,
                      tbl[i].e_ifr, tbl[i].e_ifrd, tbl[i].e_dmr, tbl[i].e_dmrd,
                      tbl[i].e_busy, tbl[i].e_err}));
        end

        // Load that is never acknowledged
        idle_in();
        dm_req = 1; dm_addr = 32'h400;
        tick();
        cnt = 0;
        for (int i = 0; i < 20 && !dm_ready; i++) begin
            if (mem_req) cnt++;
            tick();
        end
        chk("tmo_ready", 137'(dm_ready), 137'(1));
        chk("tmo_cycles", 137'(cnt), 137'(TO));
        chk("tmo_err_rdata", 137'({err, dm_rdata}), 137'({1'b1, 32'h0}));
        dm_req = 0;
        repeat (5) tick();
        chk("err_sticky", 137'(err), 137'(1));
        reset = 1;
        tick();
        reset = 0;
        chk("err_reset", 137'(err), 137'(0));

        // Ack arriving in the last allowed cycle wins over the timeout
        dm_req = 1; dm_addr = 32'h404;
        tick();
        repeat (TO - 1) tick();
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        tick();
        chk("ack_at_tmo", 137'({dm_ready, err, dm_rdata}),
            137'({1'b1, 1'b0, 32'hA5A5A5A5}));
        idle_in();
        tick();

        // Reset in the middle of a data transaction
        dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h55;
        tick();
        tick();
        reset = 1;
        tick();
        chk("rst_mid", 137'({mem_req, busy, dm_ready}), 137'(0));
        idle_in();
        mem_ack = 1; mem_rdata = 32'h77;
        saw = 0;
        repeat (3) begin
            tick();
            if (dm_ready || busy) saw = 1;
        end
        chk("rst_ack_ignored", 137'({saw, dm_rdata}), 137'(0));

        // Both requesters held high with immediate acks
        idle_in();
        dm_req = 1; dm_we = 1; dm_addr = 32'h700; dm_wdata = 32'h1;
        if_req = 1; if_addr = 32'h800; mem_ack = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (mem_req) seq.push_back(mem_addr == 32'h700);
        end
        got = seq.size();
        chk("alt_count", 137'(got >= 4), 137'(1));
        for (int i = 0; i < 4 && i < got; i++)
            chk($sformatf("alt%0d", i), 137'(seq[i]),
                137'(FAIR ? (i % 2 == 0) : 1'b1));

        // Random traffic against the reference
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            if_req = $urandom_range(0, 1) == 1;
            if_addr = $urandom;
            dm_req = $urandom_range(0, 2) == 0;
            dm_we = $urandom_range(0, 1) == 1;
            dm_addr = $urandom;
            dm_wdata = $urandom;
            dm_type = 3'($urandom);
            mem_ack = $urandom_range(0, 9) < 3;
            mem_rdata = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
